// File: rtl/bus_pkg.sv
// Shared types for the tagged 64-bit bus memory.
package bus_pkg;

  localparam int DEF_ADDR_W = 20;

  typedef logic [63:0] word_t;
  typedef logic [7:0]  tag_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RWAIT
  } mem_state_t;

endpackage

// File: rtl/bus_mem_array.sv
// DEPTH x (64+8) word/tag storage: synchronous write, registered read.
module bus_mem_array
  import bus_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] idx,
  input  logic             we,
  input  word_t            wdata,
  input  tag_t             wtag,
  input  logic             re,
  output word_t            rdata,
  output tag_t             rtag
);

  word_t mem    [DEPTH];
  tag_t  tagmem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[idx]    <= wdata;
      tagmem[idx] <= wtag;
    end
    if (re) begin
      rdata <= mem[idx];
      rtag  <= tagmem[idx];
    end
  end

endmodule

// File: rtl/bus_memory.sv
// Fixed-latency tagged word store on the cpu bus.
// BUS_MEMORY_BOUNDS_EN: flag and suppress accesses with addr >= DEPTH.
module bus_memory
  import bus_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DEPTH    = 1 << ADDR_W,
  parameter int READ_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] i_ad,
  input  logic [7:0]  i_tag,
  input  logic        i_astb,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [63:0] o_data,
  output logic [7:0]  o_tag,
  output logic        o_valid,
  output logic        o_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = 3;
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LAT - 1);

  mem_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;

  logic [ADDR_W:0]  addr_x;
  logic [IDX_W-1:0] idx;
  logic             in_addr;
  logic             wr_go;
  logic             rd_go;
  logic             we;
  logic             proto_err;
  logic             range_err;
  word_t            snap_data;
  tag_t             snap_tag;
  word_t            rd_data;
  tag_t             rd_tag;

  assign addr_x  = {1'b0, addr};
  assign idx     = IDX_W'(addr_x % DEPTH_W);
  assign in_addr = (state == ADDR) && !i_astb;
  assign wr_go   = in_addr && i_wr && !i_rd;
  assign rd_go   = in_addr && i_rd && !i_wr;

  always_comb begin
    proto_err = 1'b0;
    unique case (state)
      IDLE:    proto_err = !i_astb && (i_rd || i_wr);
      ADDR:    proto_err = !i_astb && i_rd && i_wr;
      RWAIT:   proto_err = i_astb || i_rd || i_wr;
      default: proto_err = 1'b0;
    endcase
  end

`ifdef BUS_MEMORY_BOUNDS_EN
  logic oob;
  logic oob_q;

  assign oob       = addr_x >= DEPTH_W;
  assign we        = wr_go && !oob;
  assign range_err = (wr_go || rd_go) && oob;
  assign rd_data   = oob_q ? '0 : snap_data;
  assign rd_tag    = oob_q ? '0 : snap_tag;

  // Out-of-range reads still run the full latency but return zeros.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      oob_q <= 1'b0;
    end else if (rd_go) begin
      oob_q <= oob;
    end
  end
`else
  assign we        = wr_go;
  assign range_err = 1'b0;
  assign rd_data   = snap_data;
  assign rd_tag    = snap_tag;
`endif

  bus_mem_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clk  (clk),
    .idx  (idx),
    .we   (we),
    .wdata(i_ad),
    .wtag (i_tag),
    .re   (rd_go),
    .rdata(snap_data),
    .rtag (snap_tag)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr    <= '0;
      cnt     <= '0;
      o_data  <= '0;
      o_tag   <= '0;
      o_valid <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (proto_err || range_err) begin
        o_err <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (i_astb) begin
            addr  <= i_ad[ADDR_W-1:0];
            state <= ADDR;
          end
        end
        ADDR: begin
          if (i_astb) begin
            addr <= i_ad[ADDR_W-1:0];
          end else if (rd_go) begin
            cnt   <= CNT_INIT;
            state <= RWAIT;
          end
        end
        RWAIT: begin
          // addr is kept so a bare rd afterwards re-reads the same word.
          if (cnt == '0) begin
            o_data  <= rd_data;
            o_tag   <= rd_tag;
            o_valid <= 1'b1;
            state   <= ADDR;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
